// File: rtl/lifo_fifo_pkg.sv
// Shared types and helpers for the dual-mode LIFO/FIFO buffer.
// No logic, no latency.
// No flow control.
package lifo_fifo_pkg;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } buf_mode_e;

    // Number of entries addressed by an aw-bit address
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/lifo_fifo_buf_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Read latency 1 cycle; a same-address read and write returns the old word.
// No backpressure: the controller only issues legal accesses.
module buf_ram
    import lifo_fifo_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_dat
);

    localparam int unsigned DEPTH = depth_of(AWIDTH);

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    // Storage array: contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read register: samples the pre-write word and holds it between reads
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lifo_fifo_buf.sv
// Dual-mode storage buffer: stack (LIFO) or queue (FIFO), mode chosen while empty.
// Read data appears one cycle after an accepted read; flags are registered.
// No stall: a write when full or a read when empty is dropped with a 1-cycle pulse.
module lifo_fifo_buf
    import lifo_fifo_pkg::*;
#(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 8,
    parameter int ALMOST_FULL  = 2,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              mode_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              mode_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned     DEPTH   = depth_of(AWIDTH);
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_LVL  = (AWIDTH+1)'(DEPTH - ALMOST_FULL);
    localparam logic [AWIDTH:0] AE_LVL  = (AWIDTH+1)'(ALMOST_EMPTY);

    buf_mode_e         mode_q;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   usedw_q;
    logic              empty_q;
    logic              full_q;
    logic              almost_empty_q;
    logic              almost_full_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              mode_ld;
    logic [AWIDTH-1:0] lifo_top;
    logic [AWIDTH-1:0] lifo_wslot;
    logic [AWIDTH-1:0] ram_waddr;
    logic [AWIDTH-1:0] ram_raddr;
    logic [AWIDTH:0]   usedw_nxt;

    // Accept/drop decisions, RAM addressing and next occupancy
    always_comb begin
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        mode_ld    = 1'b0;
        lifo_top   = '0;
        lifo_wslot = '0;
        ram_waddr  = '0;
        ram_raddr  = '0;
        usedw_nxt  = usedw_q;

        // A simultaneous read frees a slot, so a write to a full buffer still lands
        wr_acc  = wrreq_i && (!full_q || rdreq_i);
        // When empty a paired write is taken but the read is quietly dropped
        rd_acc  = rdreq_i && !empty_q;
        // Mode may only change while nothing is stored and nothing is arriving
        mode_ld = empty_q && !wrreq_i;

        // Stack top is usedw-1; a paired write replaces the top instead of pushing
        lifo_top   = AWIDTH'(usedw_q - 1'b1);
        lifo_wslot = rd_acc ? lifo_top : AWIDTH'(usedw_q);

        if (mode_q == MODE_LIFO) begin
            ram_waddr = lifo_wslot;
            ram_raddr = lifo_top;
        end else begin
            ram_waddr = wr_ptr;
            ram_raddr = rd_ptr;
        end

        case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw_q + 1'b1;
            2'b01:   usedw_nxt = usedw_q - 1'b1;
            default: usedw_nxt = usedw_q;
        endcase
    end

    // Mode latch, FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mode_q         <= MODE_FIFO;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            usedw_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (mode_ld) begin
                mode_q <= buf_mode_e'(mode_i);
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else if (mode_q == MODE_FIFO) begin
                if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            end
            usedw_q        <= usedw_nxt;
            empty_q        <= (usedw_nxt == '0);
            full_q         <= (usedw_nxt == DEPTH_W);
            almost_empty_q <= (usedw_nxt <= AE_LVL);
            almost_full_q  <= (usedw_nxt >= AF_LVL);
            overflow_q     <= wrreq_i && full_q && !rdreq_i;
            underflow_q    <= rdreq_i && empty_q && !wrreq_i;
        end
    end

    buf_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .wr_en    (wr_acc),
        .wr_addr  (ram_waddr),
        .wr_dat   (data_i),
        .rd_en    (rd_acc),
        .rd_addr  (ram_raddr),
        .rd_dat   (q_o)
    );

    assign mode_o         = mode_q;
    assign usedw_o        = usedw_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = almost_empty_q;
    assign almost_full_o  = almost_full_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Scoreboard bench for lifo_fifo_buf: stimulus queues the expected post-edge state,
// a monitor compares it one half-cycle after the edge it belongs to.
// Directed vectors; expected values are written out from the loop indices.
module tb_lifo_fifo_buf;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        mode_i = 1'b0;
    logic        wrreq_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        rdreq_i = 1'b0;
    logic [15:0] q_o;
    logic        mode_o;
    logic [8:0]  usedw_o;
    logic        empty_o, full_o, almost_empty_o, almost_full_o;
    logic        overflow_o, underflow_o;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          cyc;
        logic [15:0] q;
        int          u;
        bit          ov;
        bit          un;
        bit          md;
    } exp_t;

    exp_t sb[$];

    // Bench-side expectation state
    int          used = 0;
    logic [15:0] lq = '0;
    bit          exp_mode = 1'b0;

    lifo_fifo_buf dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .mode_i         (mode_i),
        .wrreq_i        (wrreq_i),
        .data_i         (data_i),
        .rdreq_i        (rdreq_i),
        .q_o            (q_o),
        .mode_o         (mode_o),
        .usedw_o        (usedw_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc_cnt, act, exp);
        end
    endtask

    // Monitor: compare every entry whose edge has passed
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = sb.pop_front();
            chk("q",            32'(q_o),            32'(e.q));
            chk("usedw",        32'(usedw_o),        32'(e.u));
            chk("empty",        32'(empty_o),        32'(e.u == 0));
            chk("full",         32'(full_o),         32'(e.u == 256));
            chk("almost_empty", 32'(almost_empty_o), 32'(e.u <= 2));
            chk("almost_full",  32'(almost_full_o),  32'(e.u >= 254));
            chk("overflow",     32'(overflow_o),     32'(e.ov));
            chk("underflow",    32'(underflow_o),    32'(e.un));
            chk("mode",         32'(mode_o),         32'(e.md));
        end
    end

    // One clock of stimulus with its expected post-edge state
    task automatic step(input bit wr, input bit rd, input logic [15:0] d,
                        input logic [15:0] qe, input int ue, input bit ove, input bit une);
        exp_t e;
        wrreq_i = wr;
        rdreq_i = rd;
        data_i  = d;
        e.cyc = cyc_cnt + 1;
        e.q   = qe;
        e.u   = ue;
        e.ov  = ove;
        e.un  = une;
        e.md  = exp_mode;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
    endtask

    task automatic do_wr(input logic [15:0] d);
        used++;
        step(1'b1, 1'b0, d, lq, used, 1'b0, 1'b0);
    endtask

    task automatic do_rd(input logic [15:0] qe);
        used--;
        lq = qe;
        step(1'b0, 1'b1, 16'h0, qe, used, 1'b0, 1'b0);
    endtask

    task automatic do_idle();
        step(1'b0, 1'b0, 16'h0, lq, used, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_q"},     32'(q_o),            32'h0);
        chk({tag, "_mode"},  32'(mode_o),         32'h0);
        chk({tag, "_usedw"}, 32'(usedw_o),        32'h0);
        chk({tag, "_empty"}, 32'(empty_o),        32'h1);
        chk({tag, "_ae"},    32'(almost_empty_o), 32'h1);
        chk({tag, "_full"},  32'(full_o),         32'h0);
        chk({tag, "_af"},    32'(almost_full_o),  32'h0);
        chk({tag, "_ovf"},   32'(overflow_o),     32'h0);
        chk({tag, "_unf"},   32'(underflow_o),    32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        arst_n = 1'b1;

        // LIFO: 256 pushes then 256 pops come back reversed
        mode_i = 1'b1; exp_mode = 1'b1;
        do_idle();
        for (int i = 0; i < 256; i++) do_wr(16'(i));
        for (int i = 0; i < 256; i++) do_rd(16'(255 - i));

        // LIFO: read from empty three times
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, lq, 0, 1'b0, 1'b1);

        // LIFO full, paired write+read replaces top
        for (int i = 0; i < 256; i++) do_wr(16'(i));
        step(1'b1, 1'b1, 16'hBEEF, 16'd255, 256, 1'b0, 1'b0);
        lq = 16'd255;
        do_rd(16'hBEEF);
        for (int i = 254; i >= 0; i--) do_rd(16'(i));

        // FIFO: fill, one overflow, drain in order, then underflows
        mode_i = 1'b0; exp_mode = 1'b0;
        do_idle();
        for (int i = 0; i < 256; i++) do_wr(16'(i));
        step(1'b1, 1'b0, 16'd999, lq, 256, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) do_rd(16'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0, lq, 0, 1'b0, 1'b1);

        // FIFO full, paired write+read returns oldest
        for (int i = 0; i < 256; i++) do_wr(16'(16'h0100 + i));
        step(1'b1, 1'b1, 16'hBEEF, 16'h0100, 256, 1'b0, 1'b0);
        lq = 16'h0100;
        for (int i = 1; i < 256; i++) do_rd(16'(16'h0100 + i));
        do_rd(16'hBEEF);

        // mode_i ignored while words are stored or a write arrives
        mode_i = 1'b1;
        for (int k = 0; k < 5; k++) do_wr(16'(10 + k));
        do_idle();
        do_idle();
        for (int k = 0; k < 5; k++) do_rd(16'(10 + k));
        exp_mode = 1'b1;
        do_idle();
        do_wr(16'd1); do_wr(16'd2); do_wr(16'd3);
        do_rd(16'd3); do_rd(16'd2); do_rd(16'd1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 100; i++) do_wr(16'(16'h0500 + i));
        wrreq_i = 1'b1;
        data_i  = 16'hAAAA;
        mode_i  = 1'b0;
        #2 arst_n = 1'b0;
        #1 chk_reset_outputs("arst");
        @(negedge clk);
        wrreq_i = 1'b0;
        arst_n = 1'b1;
        used = 0; lq = '0; exp_mode = 1'b0;
        do_wr(16'h1234);
        do_wr(16'h5678);
        do_rd(16'h1234);
        do_rd(16'h5678);

        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
